unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the pipeline's fetch stage (I port, read-only) and memory stage (D port, read/write).
- Allows one outstanding memory transaction at a time.
- Data access has priority over fetch; a starvation limit guarantees fetch progress.
- Supports fetch flush on redirect, so stale instruction responses are dropped.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, memory word width.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits; then fetch wins.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- i_req_i  input  1  fetch request
- i_addr_i  input  ADDR_WIDTH  fetch address
- i_gnt_o  output  1  fetch request accepted (1-cycle pulse)
- i_rvalid_o  output  1  fetch data valid
- i_rdata_o  output  DATA_WIDTH  fetch data
- flush_i  input  1  redirect; discard in-flight fetch response
- d_req_i  input  1  data request
- d_we_i  input  1  1 = write
- d_be_i  input  DATA_WIDTH/8  byte enables
- d_addr_i  input  ADDR_WIDTH  data address
- d_wdata_i  input  DATA_WIDTH  write data
- d_gnt_o  output  1  data request accepted
- d_rvalid_o  output  1  read data valid / write acknowledge
- d_rdata_o  output  DATA_WIDTH  read data
- m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o  output  1/1/DATA_WIDTH/8/ADDR_WIDTH/DATA_WIDTH  memory request
- m_gnt_i  input  1  memory accepts request
- m_rvalid_i  input  1  memory response (reads and writes)
- m_rdata_i  input  DATA_WIDTH  memory read data
- busy_o  output  1  state != IDLE

Behaviour:
- Reset (synchronous):
  - state = IDLE; owner = D; starve_cnt = 0; drop = 0; latched fields = 0.
  - All outputs 0.
  - Reset mid-transaction abandons it; a late m_rvalid_i arriving in IDLE is ignored.
- FSM IDLE / REQ / RSP:
  - IDLE, arbitration (combinational):
    - sel = D if d_req_i && (!i_req_i || starve_cnt < STARVE_LIMIT).
    - Otherwise sel = I if i_req_i.
    - If neither is requesting: m_req_o = 0.
  - IDLE, drive and latch:
    - m_* are driven combinationally from the sel port's inputs (I port: we = 0, be = all-ones, wdata = 0).
    - owner and all request fields are latched.
  - IDLE, grant:
    - If m_gnt_i: pulse sel's gnt the same cycle, go to RSP.
    - Otherwise go to REQ.
  - REQ:
    - m_* are driven from the latched registers; the request is never retracted even if the requester drops its request.
    - On m_gnt_i: pulse owner's gnt, go to RSP.
  - RSP:
    - m_req_o = 0.
    - On m_rvalid_i: route m_rdata_i to owner's rdata and pulse owner's rvalid, go to IDLE.
    - Minimum transaction: 2 cycles (grant in IDLE, response next cycle).
  - m_rvalid_i outside RSP is ignored.
- rdata outputs hold their last value; only rvalid qualifies them.
- Starvation counter:
  - On a D grant while i_req_i is high: starve_cnt++, saturating at STARVE_LIMIT.
  - On an I grant, or a D grant with i_req_i low: starve_cnt = 0.
- Flush:
  - flush_i while owner == I and state is REQ or RSP: drop = 1.
  - A fetch response arriving with drop = 1, or in the same cycle as flush_i, is consumed with i_rvalid_o = 0.
  - drop clears on return to IDLE.
  - flush_i has no effect when owner == D or state == IDLE.
- A request is granted only when the port's req is high in IDLE, or when latched in REQ.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_i_wait_o[31:0] and perf_d_wait_o[31:0].
  - Each counts cycles in which the port's req is high and its gnt is low.
  - Counters saturate at 2^32-1 and clear on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- common/pipeline_types.svh holds:
  - mem_arb_state_e (IDLE, REQ, RSP)
  - mem_arb_owner_e (OWNER_I, OWNER_D)
  - the ADDR/DATA width defines already used by the pipeline.
- One sub-module, mem_arb_perf_counter (saturating 32-bit counter), is instantiated twice under MEM_ARB_PERF_EN.

Test Plan:
- I only: i_req_i = 1, i_addr_i = 0x100, m_gnt_i = 1 immediately, m_rvalid_i one cycle later with 0x00500093 -> i_gnt_o pulses at cycle 0; i_rvalid_o = 1 with i_rdata_o = 0x00500093 at cycle 1; busy_o is 1 for exactly 1 cycle.
- Simultaneous: both ports request, D write to 0x200 with be = 4'b0011 -> D granted first, m_we_o = 1, m_be_o = 0011; I granted on the next IDLE cycle.
- Starvation: i_req_i held high, d_req_i held high, STARVE_LIMIT = 4 -> grant order D, D, D, D, I, D…; starve_cnt returns to 0 after the I grant.
- Grant backpressure: m_gnt_i low for 3 cycles; I requester deasserts i_req_i and changes i_addr_i after cycle 0 -> m_addr_o stays at the original address and m_req_o stays high until the grant.
- Flush: I in RSP, flush_i pulses, then m_rvalid_i arrives -> i_rvalid_o stays 0 and the next transaction proceeds normally. Repeat with flush_i in the same cycle as m_rvalid_i -> response also dropped.
- Reset mid-RSP: rst asserted for 1 cycle, then m_rvalid_i = 1 -> no rvalid output, busy_o = 0; with MEM_ARB_PERF_EN, both perf counters read 0.

Source files
------------

// File: rtl/unified_mem_arbiter_pkg.sv
// rtl/unified_mem_arbiter_pkg.sv - shared widths and FSM/owner types for the unified memory arbiter
package unified_mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } mem_arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } mem_arb_owner_e;

endpackage

// File: rtl/unified_mem_arbiter_perf_counter.sv
// rtl/unified_mem_arbiter_perf_counter.sv - saturating 32-bit event counter used for arbiter wait statistics
module unified_mem_arbiter_perf_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  output logic [31:0] o_count
);

  // Count qualifying cycles, sticking at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      o_count <= '0;
    end else if (i_inc && (o_count != 32'hFFFF_FFFF)) begin
      o_count <= o_count + 32'd1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - fetch/data arbiter for a single-ported unified memory (optional MEM_ARB_PERF_EN wait counters)
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = MEM_ADDR_W,
  parameter int DATA_WIDTH   = MEM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req_i,
  input  logic [ADDR_WIDTH-1:0]   i_addr_i,
  output logic                    i_gnt_o,
  output logic                    i_rvalid_o,
  output logic [DATA_WIDTH-1:0]   i_rdata_o,
  input  logic                    flush_i,
  input  logic                    d_req_i,
  input  logic                    d_we_i,
  input  logic [DATA_WIDTH/8-1:0] d_be_i,
  input  logic [ADDR_WIDTH-1:0]   d_addr_i,
  input  logic [DATA_WIDTH-1:0]   d_wdata_i,
  output logic                    d_gnt_o,
  output logic                    d_rvalid_o,
  output logic [DATA_WIDTH-1:0]   d_rdata_o,
  output logic                    m_req_o,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic                    m_gnt_i,
  input  logic                    m_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  output logic                    busy_o
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]             perf_i_wait_o,
  output logic [31:0]             perf_d_wait_o
`endif
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  mem_arb_state_e        r_state;
  mem_arb_owner_e        r_owner;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic                  r_drop;
  logic                  r_we;
  logic [BE_W-1:0]       r_be;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_i_rdata;
  logic [DATA_WIDTH-1:0] r_d_rdata;

  logic                  w_sel_d;
  logic                  w_sel_i;
  logic                  w_flush_hit;
  logic                  w_sel_we;
  logic [BE_W-1:0]       w_sel_be;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // Data wins unless fetch has already waited through STARVE_LIMIT data grants
  assign w_sel_d = d_req_i && (!i_req_i || (r_starve_cnt < LIMIT));
  assign w_sel_i = i_req_i && !w_sel_d;

  // Fields of the winning port; a fetch is always a full-word read
  assign w_sel_we    = w_sel_d ? d_we_i    : 1'b0;
  assign w_sel_be    = w_sel_d ? d_be_i    : {BE_W{1'b1}};
  assign w_sel_addr  = w_sel_d ? d_addr_i  : i_addr_i;
  assign w_sel_wdata = w_sel_d ? d_wdata_i : '0;

  // A redirect only matters while a fetch owns the memory
  assign w_flush_hit = flush_i && (r_owner == OWNER_I) && (r_state != IDLE);

  // Memory request, grant pulses and response routing; everything is quiet while reset is high
  always_comb begin
    m_req_o    = 1'b0;
    m_we_o     = 1'b0;
    m_be_o     = '0;
    m_addr_o   = '0;
    m_wdata_o  = '0;
    i_gnt_o    = 1'b0;
    d_gnt_o    = 1'b0;
    i_rvalid_o = 1'b0;
    d_rvalid_o = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_sel_d || w_sel_i) begin
            m_req_o   = 1'b1;
            m_we_o    = w_sel_we;
            m_be_o    = w_sel_be;
            m_addr_o  = w_sel_addr;
            m_wdata_o = w_sel_wdata;
            d_gnt_o   = w_sel_d && m_gnt_i;
            i_gnt_o   = w_sel_i && m_gnt_i;
          end
        end
        REQ: begin
          m_req_o   = 1'b1;
          m_we_o    = r_we;
          m_be_o    = r_be;
          m_addr_o  = r_addr;
          m_wdata_o = r_wdata;
          d_gnt_o   = (r_owner == OWNER_D) && m_gnt_i;
          i_gnt_o   = (r_owner == OWNER_I) && m_gnt_i;
        end
        RSP: begin
          if (m_rvalid_i) begin
            d_rvalid_o = (r_owner == OWNER_D);
            i_rvalid_o = (r_owner == OWNER_I) && !r_drop && !flush_i;
          end
        end
        default: ;
      endcase
    end
  end

  // Read data is visible in the response cycle and held afterwards
  assign i_rdata_o = i_rvalid_o ? m_rdata_i : r_i_rdata;
  assign d_rdata_o = d_rvalid_o ? m_rdata_i : r_d_rdata;
  assign busy_o    = !rst && (r_state != IDLE);

  // Transaction FSM: latch the winner in IDLE, hold it in REQ, wait for the response in RSP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= OWNER_D;
      r_drop  <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sel_d || w_sel_i) begin
            r_owner <= w_sel_d ? OWNER_D : OWNER_I;
            r_we    <= w_sel_we;
            r_be    <= w_sel_be;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_state <= m_gnt_i ? RSP : REQ;
          end
        end
        REQ: begin
          if (w_flush_hit) r_drop <= 1'b1;
          if (m_gnt_i) r_state <= RSP;
        end
        RSP: begin
          if (m_rvalid_i) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
          end else if (w_flush_hit) begin
            r_drop <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Consecutive data grants taken while fetch was waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (d_gnt_o && i_req_i) begin
      if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else if (d_gnt_o || i_gnt_o) begin
      r_starve_cnt <= '0;
    end
  end

  // Hold the last delivered read data for each port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (i_rvalid_o) r_i_rdata <= m_rdata_i;
      if (d_rvalid_o) r_d_rdata <= m_rdata_i;
    end
  end

`ifdef MEM_ARB_PERF_EN
  unified_mem_arbiter_perf_counter u_perf_i (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (i_req_i && !i_gnt_o),
    .o_count (perf_i_wait_o)
  );

  unified_mem_arbiter_perf_counter u_perf_d (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (d_req_i && !d_gnt_o),
    .o_count (perf_d_wait_o)
  );
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        flush_i;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        m_req_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_addr_o;
  logic [31:0] m_wdata_o;
  logic        m_gnt_i;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        busy_o;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_i_wait_o;
  logic [31:0] perf_d_wait_o;
`endif

  unified_mem_arbiter #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_req_i    (i_req_i),
    .i_addr_i   (i_addr_i),
    .i_gnt_o    (i_gnt_o),
    .i_rvalid_o (i_rvalid_o),
    .i_rdata_o  (i_rdata_o),
    .flush_i    (flush_i),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_be_i     (d_be_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_gnt_o    (d_gnt_o),
    .d_rvalid_o (d_rvalid_o),
    .d_rdata_o  (d_rdata_o),
    .m_req_o    (m_req_o),
    .m_we_o     (m_we_o),
    .m_be_o     (m_be_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_gnt_i    (m_gnt_i),
    .m_rvalid_i (m_rvalid_i),
    .m_rdata_i  (m_rdata_i),
    .busy_o     (busy_o)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_i_wait_o (perf_i_wait_o),
    .perf_d_wait_o (perf_d_wait_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Reference memory: what a read of any word should return given all writes granted so far
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] mm_mem[logic [31:0]];
  logic [31:0] exp_i[$];
  logic [31:0] exp_d[$];

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] mm_rd(input logic [31:0] a);
    return mm_mem.exists(a) ? mm_mem[a] : dflt(a);
  endfunction

  // Random-latency memory: grants at random, answers 1..3 cycles after acceptance
  bit mm_auto = 1'b0;
  bit mm_pend = 1'b0;
  int mm_wait = 0;
  logic [31:0] mm_data = '0;
  initial forever begin
    @(posedge clk);
    #2;
    if (mm_auto) begin
      m_rvalid_i = 1'b0;
      if (mm_pend) begin
        if (mm_wait == 0) begin
          m_rvalid_i = 1'b1;
          m_rdata_i  = mm_data;
          mm_pend    = 1'b0;
        end else begin
          mm_wait--;
        end
      end
      m_gnt_i = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (m_req_o && m_gnt_i) begin
        mm_pend = 1'b1;
        mm_wait = $urandom_range(0, 2);
        if (m_we_o) begin
          mm_mem[m_addr_o] = merge(mm_rd(m_addr_o), m_wdata_o, m_be_o);
          mm_data = 32'h0;
        end else begin
          mm_data = mm_rd(m_addr_o);
        end
      end
    end
  end

  // Monitor: every delivered response must match the oldest expectation of its port
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (i_rvalid_o) begin
        if (exp_i.size() == 0) fail_now("i_resp_unexpected");
        else chk("i_rdata", i_rdata_o, exp_i.pop_front());
      end
      if (d_rvalid_o) begin
        if (exp_d.size() == 0) fail_now("d_resp_unexpected");
        else chk("d_rdata", d_rdata_o, exp_d.pop_front());
      end
      if (i_gnt_o || d_gnt_o) chk("gnt_exclusive", {31'd0, i_gnt_o & d_gnt_o}, 32'd0);
    end
  end

  task automatic drive_i(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      int w;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      tick();
      a = $urandom_range(0, 15) << 2;
      i_req_i  = 1'b1;
      i_addr_i = a;
      w = 0;
      forever begin
        smp();
        if (i_gnt_o || w > 300) break;
        w++;
      end
      if (w > 300) fail_now("i_grant_timeout");
      else exp_i.push_back(ref_rd(a));
      tick();
      i_req_i = 1'b0;
    end
  endtask

  task automatic drive_d(input int n);
    for (int k = 0; k < n; k++) begin
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      logic        we;
      int w;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      tick();
      a  = $urandom_range(0, 15) << 2;
      wd = $urandom;
      be = 4'($urandom_range(1, 15));
      we = 1'($urandom_range(0, 1));
      d_req_i = 1'b1; d_we_i = we; d_be_i = be; d_addr_i = a; d_wdata_i = wd;
      w = 0;
      forever begin
        smp();
        if (d_gnt_o || w > 300) break;
        w++;
      end
      if (w > 300) begin
        fail_now("d_grant_timeout");
      end else if (we) begin
        ref_mem[a] = merge(ref_rd(a), wd, be);
        exp_d.push_back(32'h0);
      end else begin
        exp_d.push_back(ref_rd(a));
      end
      tick();
      d_req_i = 1'b0;
    end
  endtask

  initial begin
    int drain;
    rst = 1'b1;
    i_req_i = 0; i_addr_i = 0; flush_i = 0;
    d_req_i = 0; d_we_i = 0; d_be_i = 0; d_addr_i = 0; d_wdata_i = 0;
    m_gnt_i = 0; m_rvalid_i = 0; m_rdata_i = 0;

    // Reset state
    tick(); tick();
    i_req_i = 1'b1; d_req_i = 1'b1; m_gnt_i = 1'b1;
    smp();
    chk("rst_m_req", {31'd0, m_req_o}, 32'd0);
    chk("rst_gnts", {30'd0, i_gnt_o, d_gnt_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_i_rdata", i_rdata_o, 32'd0);
    tick();
    i_req_i = 0; d_req_i = 0; m_gnt_i = 0; rst = 1'b0;

    // Fetch only, immediate grant, response next cycle
    tick();
    i_req_i = 1; i_addr_i = 32'h100; m_gnt_i = 1;
    smp();
    chk("ionly_gnt", {31'd0, i_gnt_o}, 32'd1);
    chk("ionly_addr", m_addr_o, 32'h100);
    chk("ionly_we_be", {27'd0, m_we_o, m_be_o}, 32'h0F);
    chk("ionly_busy0", {31'd0, busy_o}, 32'd0);
    tick();
    i_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h0050_0093;
    smp();
    chk("ionly_rvalid", {31'd0, i_rvalid_o}, 32'd1);
    chk("ionly_rdata", i_rdata_o, 32'h0050_0093);
    chk("ionly_busy1", {31'd0, busy_o}, 32'd1);
    tick();
    m_rvalid_i = 0; m_rdata_i = 32'hFFFF_FFFF;
    smp();
    chk("ionly_busy2", {31'd0, busy_o}, 32'd0);
    chk("ionly_hold", i_rdata_o, 32'h0050_0093);

    // Simultaneous requests: data write first, fetch next
    tick();
    i_req_i = 1; i_addr_i = 32'h104;
    d_req_i = 1; d_we_i = 1; d_be_i = 4'b0011; d_addr_i = 32'h200; d_wdata_i = 32'hDEAD_BEEF;
    m_gnt_i = 1;
    smp();
    chk("sim_d_first", {30'd0, i_gnt_o, d_gnt_o}, 32'd1);
    chk("sim_we_be", {27'd0, m_we_o, m_be_o}, 32'h13);
    chk("sim_addr", m_addr_o, 32'h200);
    tick();
    d_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h0;
    smp();
    chk("sim_d_ack", {31'd0, d_rvalid_o}, 32'd1);
    tick();
    m_rvalid_i = 0; m_gnt_i = 1;
    smp();
    chk("sim_i_next", {30'd0, i_gnt_o, d_gnt_o}, 32'd2);
    chk("sim_i_addr", m_addr_o, 32'h104);
    tick();
    i_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h1111_1111;
    smp();
    chk("sim_i_rdata", i_rdata_o, 32'h1111_1111);
    tick();
    m_rvalid_i = 0;

    // Starvation: both held high, fetch wins every fifth grant
    i_req_i = 1; i_addr_i = 32'h180; d_req_i = 1; d_we_i = 0; d_addr_i = 32'h20;
    for (int k = 0; k < 10; k++) begin
      tick();
      m_gnt_i = 1; m_rvalid_i = 0;
      smp();
      chk($sformatf("starve_grant%0d", k), {30'd0, i_gnt_o, d_gnt_o}, ((k % 5) == 4) ? 32'd2 : 32'd1);
      tick();
      m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'(k);
    end
    tick();
    i_req_i = 0; d_req_i = 0; m_rvalid_i = 0;

    // Grant backpressure: request held from latched fields after the fetch withdraws
    tick();
    i_req_i = 1; i_addr_i = 32'h300; m_gnt_i = 0;
    smp();
    chk("bp_req0", {31'd0, m_req_o}, 32'd1);
    for (int k = 1; k < 3; k++) begin
      tick();
      i_req_i = 0; i_addr_i = 32'h999;
      smp();
      chk($sformatf("bp_req%0d", k), {31'd0, m_req_o}, 32'd1);
      chk($sformatf("bp_addr%0d", k), m_addr_o, 32'h300);
    end
    tick();
    m_gnt_i = 1;
    smp();
    chk("bp_gnt", {31'd0, i_gnt_o}, 32'd1);
    chk("bp_gnt_addr", m_addr_o, 32'h300);
    tick();
    m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h3333_3333;
    smp();
    chk("bp_rvalid", {31'd0, i_rvalid_o}, 32'd1);
    tick();
    m_rvalid_i = 0;

    // Flush before response, then flush in the response cycle
    for (int f = 0; f < 2; f++) begin
      tick();
      i_req_i = 1; i_addr_i = 32'h400; m_gnt_i = 1;
      tick();
      i_req_i = 0; m_gnt_i = 0; flush_i = (f == 0);
      tick();
      flush_i = (f == 1); m_rvalid_i = 1; m_rdata_i = 32'h0BAD_0BAD;
      smp();
      chk($sformatf("flush%0d_drop", f), {31'd0, i_rvalid_o}, 32'd0);
      chk($sformatf("flush%0d_hold", f), i_rdata_o, 32'h3333_3333);
      tick();
      flush_i = 0; m_rvalid_i = 0;
      smp();
      chk($sformatf("flush%0d_idle", f), {31'd0, busy_o}, 32'd0);
    end
    tick();
    i_req_i = 1; i_addr_i = 32'h404; m_gnt_i = 1;
    tick();
    i_req_i = 0; m_gnt_i = 0; m_rvalid_i = 1; m_rdata_i = 32'h1234_5678;
    smp();
    chk("post_flush_rdata", {i_rvalid_o ? i_rdata_o : 32'hFFFF_FFFF}, 32'h1234_5678);
    tick();
    m_rvalid_i = 0;

    // Reset while a data read waits for its response
    tick();
    d_req_i = 1; d_we_i = 0; d_addr_i = 32'h10; m_gnt_i = 1;
    tick();
    d_req_i = 0; m_gnt_i = 0; rst = 1;
    tick();
    rst = 0; m_rvalid_i = 1; m_rdata_i = 32'h7777_7777;
    smp();
    chk("rstmid_d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    chk("rstmid_busy", {31'd0, busy_o}, 32'd0);
    chk("rstmid_d_rdata", d_rdata_o, 32'd0);
`ifdef MEM_ARB_PERF_EN
    chk("rstmid_perf_i", perf_i_wait_o, 32'd0);
    chk("rstmid_perf_d", perf_d_wait_o, 32'd0);
`endif
    tick();
    m_rvalid_i = 0;

    // Randomized traffic against the reference memory
    mm_auto = 1'b1;
    mon_en  = 1'b1;
    fork
      drive_i(80);
      drive_d(80);
    join
    drain = 0;
    while ((exp_i.size() != 0 || exp_d.size() != 0) && drain < 100) begin
      @(posedge clk);
      drain++;
    end
    chk("drain_i", exp_i.size(), 32'd0);
    chk("drain_d", exp_d.size(), 32'd0);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
